// File: rtl/instr_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit and the core top.
package instr_prefetch_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = '0;
    localparam logic [INST_W-1:0] INST_NOP         = 32'h0000_0013;

    // One buffered fetch result: instruction word, access-fault flag and its PC.
    localparam int unsigned ENTRY_W = INST_W + 1 + XLEN;

    typedef struct packed {
        logic [INST_W-1:0] data;
        logic              err;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; the head entry is read
// straight from registered storage, so a push becomes visible the next cycle.
module prefetch_fifo
    import instr_prefetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    fetch_entry_t  mem_q [DEPTH];

    // Pointers wrap at DEPTH-1 so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Storage, pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the storage is reset because the head is visible on the
            // output ports, which must read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetcher: issues word fetches under a credit limit,
// buffers in-order responses with their PCs, and on a redirect flushes the
// buffer and silently discards every response still owed by memory.
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    cnt_t            outstanding_q, outstanding_d;
    cnt_t            discard_q, discard_d;

    cnt_t         fifo_count;
    cnt_t         credit_used;
    logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic         req_fire, rsp_accept, rsp_drop;
    fetch_entry_t push_entry, head_entry;

    // Request credit, handshake decode and the next-state of PCs and counters.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        // Buffered + in flight (live or doomed) may never exceed the FIFO size.
        credit_used    = fifo_count + outstanding_q + discard_q;
        imem_req_valid = !reset && (credit_used < cnt_t'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_accept     = imem_rsp_valid && !redirect_valid && (discard_q == '0);
        rsp_drop       = imem_rsp_valid && !redirect_valid && (discard_q != '0);

        if (redirect_valid) begin
            // Everything still owed by memory, including a request firing now
            // with the old address, becomes a response to throw away.
            fetch_pc_d    = align_word(redirect_pc);
            rsp_pc_d      = align_word(redirect_pc);
            discard_d     = discard_q + outstanding_q + cnt_t'(req_fire)
                          - cnt_t'(imem_rsp_valid);
            outstanding_d = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_accept) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_accept);
            discard_d     = discard_q - cnt_t'(rsp_drop);
        end
    end

    // State register for PCs and credit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;

    assign push_entry = '{data: imem_rsp_data, err: imem_rsp_err, pc: rsp_pc_q};
    assign fifo_push  = rsp_accept;
    assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .flush_i      (redirect_valid),
        .head_o       (head_entry),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = head_entry.data;
    assign inst_pc    = head_entry.pc;
    assign inst_err   = head_entry.err;

    // The credit limit must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: a queue-based memory and
// fetch model predicts every output each cycle, plus directed literal checks.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_err;

    instr_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: every request the memory has accepted and not yet answered, in
    // order, tagged stale if a redirect happened after it was issued.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] data;
        bit          err;
        logic [31:0] pc;
    } ent_t;

    req_t        mq[$];
    ent_t        fq[$];
    logic [31:0] m_fetch_pc;

    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];
    bit          pop_err[$];
    int          pop_cyc[$];

    int          cyc;
    int          fire_count;
    int          mem_lat;
    bit          mem_ready;
    bit          dec_ready;
    logic [31:0] err_addr;
    bit          redir_req;
    logic [31:0] redir_target;

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Assert reset (possibly mid-stream), check reset outputs at once, clear model.
    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;          // responses during reset must be ignored
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_rsp_err   = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check("rst_req_valid",  imem_req_valid, 32'h0);
        check("rst_req_addr",   imem_req_addr,  32'h0);
        check("rst_inst_valid", inst_valid,     32'h0);
        check("rst_inst_data",  inst_data,      32'h0);
        check("rst_inst_pc",    inst_pc,        32'h0);
        check("rst_inst_err",   inst_err,       32'h0);
        mq.delete();
        fq.delete();
        pop_pc.delete();
        pop_data.delete();
        pop_err.delete();
        pop_cyc.delete();
        m_fetch_pc = 32'h0;
        fire_count = 0;
        redir_req  = 1'b0;
        repeat (2) @(posedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        #2;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, advance it.
    task automatic step();
        bit          rsp_now, exp_valid, fire, pop, redir;
        logic [31:0] rsp_addr;
        req_t        r;
        @(negedge clk);
        redir     = redir_req;
        redir_req = 1'b0;
        rsp_now   = (mq.size() > 0) && (mq[0].due <= cyc);
        rsp_addr  = rsp_now ? mq[0].addr : 32'h0;
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = ~rsp_addr;
        imem_rsp_err   = rsp_now && (rsp_addr == err_addr);
        imem_req_ready = mem_ready;
        inst_ready     = dec_ready;
        redirect_valid = redir;
        redirect_pc    = redir_target;
        #1;
        exp_valid = (fq.size() + mq.size()) < DEPTH;
        check("req_valid",  imem_req_valid, exp_valid);
        check("req_addr",   imem_req_addr,  m_fetch_pc);
        check("inst_valid", inst_valid,     fq.size() > 0);
        if (fq.size() > 0) begin
            check("inst_pc",   inst_pc,   fq[0].pc);
            check("inst_data", inst_data, fq[0].data);
            check("inst_err",  inst_err,  fq[0].err);
        end
        fire = exp_valid && mem_ready;
        pop  = (fq.size() > 0) && dec_ready && !redir;
        if (pop) begin
            pop_pc.push_back(fq[0].pc);
            pop_data.push_back(fq[0].data);
            pop_err.push_back(fq[0].err);
            pop_cyc.push_back(cyc);
            fq.delete(0);
        end
        if (rsp_now) begin
            r = mq[0];
            mq.delete(0);
            if (!r.stale && !redir)
                fq.push_back('{data: ~r.addr, err: (r.addr == err_addr), pc: r.addr});
        end
        if (redir) begin
            fq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
        end
        if (fire) begin
            mq.push_back('{addr: m_fetch_pc, due: cyc + mem_lat, stale: redir});
            fire_count++;
        end
        if (redir)
            m_fetch_pc = {redir_target[31:2], 2'b00};
        else if (fire)
            m_fetch_pc = m_fetch_pc + 32'd4;
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int idx;
        int stale_seen;
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        cyc        = 0;
        fire_count = 0;
        err_addr   = 32'h1;             // unaligned: never matches a fetch
        redir_req  = 1'b0;
        redir_target = 32'h0;

        // 1: streaming with 1-cycle memory, decode always ready.
        mem_lat = 1; mem_ready = 1'b1; dec_ready = 1'b1;
        do_reset();
        run(10);
        check("t1_pc0", pop_pc[0], 32'h0);
        check("t1_pc1", pop_pc[1], 32'h4);
        check("t1_pc2", pop_pc[2], 32'h8);
        check("t1_data0", pop_data[0], 32'hFFFF_FFFF);
        check("t1_first_pop_cycle", pop_cyc[0], 32'd2);
        check("t1_back_to_back", pop_cyc[2] - pop_cyc[1], 32'd1);

        // 2: decode stalled: exactly DEPTH requests, then drain in order.
        dec_ready = 1'b0;
        do_reset();
        run(8);
        check("t2_fires", fire_count, 32'd4);
        check("t2_req_stalled", imem_req_valid, 32'h0);
        dec_ready = 1'b1;
        run(6);
        check("t2_pop0", pop_pc[0], 32'h0);
        check("t2_pop1", pop_pc[1], 32'h4);
        check("t2_pop2", pop_pc[2], 32'h8);
        check("t2_pop3", pop_pc[3], 32'hC);

        // 3: 3-cycle memory, two requests in flight, redirect to 0x100.
        mem_lat = 3; dec_ready = 1'b1;
        do_reset();
        run(2);
        mem_ready = 1'b0;
        redir_req = 1'b1; redir_target = 32'h100;
        step();
        mem_ready = 1'b1;
        run(10);
        check("t3_first_pc", pop_pc[0], 32'h100);
        check("t3_first_data", pop_data[0], ~32'h100);
        stale_seen = 0;
        foreach (pop_pc[i]) if (pop_pc[i] < 32'h100) stale_seen++;
        check("t3_no_stale", stale_seen, 32'd0);

        // 4: redirect in the same cycle as a request fire and a response.
        mem_lat = 2; dec_ready = 1'b0;
        do_reset();
        run(2);
        redir_req = 1'b1; redir_target = 32'h100;
        step();
        dec_ready = 1'b1;
        run(8);
        check("t4_first_pc", pop_pc[0], 32'h100);
        check("t4_second_pc", pop_pc[1], 32'h104);

        // 5: wrap at the top of the address space, then an unaligned target.
        mem_lat = 1;
        do_reset();
        redir_req = 1'b1; redir_target = 32'hFFFF_FFFC;
        run(6);
        check("t5_wrap_pc0", pop_pc[0], 32'hFFFF_FFFC);
        check("t5_wrap_pc1", pop_pc[1], 32'h0);
        idx = pop_pc.size();
        redir_req = 1'b1; redir_target = 32'h103;
        run(6);
        check("t5_align_pc", pop_pc[idx], 32'h100);

        // 6: access fault at 0x8 travels with that instruction only, then a
        // reset while the stream is running.
        err_addr = 32'h8;
        do_reset();
        run(8);
        check("t6_pc2", pop_pc[2], 32'h8);
        check("t6_err2", pop_err[2], 32'h1);
        check("t6_err1", pop_err[1], 32'h0);
        check("t6_err3", pop_err[3], 32'h0);
        do_reset();
        run(4);
        check("t6_post_reset_pc0", pop_pc[0], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
